// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-port, fixed-latency RAM between the
// CPU instruction fetch (IF, read-only) and data memory (MEM, read/write)
// requesters. MEM wins contested cycles unless IF has lost MAX_STARVE
// contested grants in a row. Each access walks IDLE -> ISSUE -> WAIT -> DONE.
//
// Handshake: each requester raises req (a level) and holds address and data
// until its one-cycle ready pulse. Addresses and write data are sampled only
// on the grant cycle in IDLE. stall_* is req & ~ready, so a requester stays
// stalled from the first cycle of its request up to its ready cycle.
//
// MEM_LAT legal range 1..15, MAX_STARVE legal range 1..15 (4-bit counters).
module pipe_mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int MAX_STARVE = 4
) (
    input  logic        clock,
    input  logic        reset,
    // instruction fetch requester
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    // data memory requester
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    // pipeline hold levels
    output logic        stall_if,
    output logic        stall_mem,
    // RAM side
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    // grant owner: 0 = IF, 1 = MEM
    output logic        owner,
    // FSM state for observation: 0=IDLE 1=ISSUE 2=WAIT 3=DONE
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_W    = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_W = 4'(MAX_STARVE);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic [3:0] wait_cnt;
    logic       contested;
    logic       grant_mem;
    logic       grant_if;
    logic       grant_any;
    logic       last_wait;

    assign state_dbg = state;

    // Arbitration decode; only acted upon while the FSM sits in IDLE.
    always_comb begin
        contested = if_req & mem_req;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        if (state == IDLE) begin
            grant_mem = mem_req & (~if_req | (starve_cnt < STARVE_W));
            grant_if  = if_req & ~grant_mem;
        end
        grant_any = grant_mem | grant_if;
        last_wait = (state == WAIT) && (wait_cnt == 4'd1);
    end

    // Stall levels follow the request directly so a hold takes effect
    // in the same cycle the request appears.
    always_comb begin
        stall_if  = if_req & ~if_ready;
        stall_mem = mem_req & ~mem_ready;
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: DONE always returns to IDLE without arbitrating, so a
    // requester still holding req during its ready cycle is not reissued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the granted request onto the RAM command registers; these hold
    // between grants. IF grants leave ram_wdata untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_addr  <= 32'd0;
            ram_we    <= 1'b0;
            ram_wdata <= 32'd0;
            owner     <= 1'b0;
        end else if (grant_mem) begin
            ram_addr  <= mem_addr;
            ram_we    <= mem_we;
            ram_wdata <= mem_wdata;
            owner     <= 1'b1;
        end else if (grant_if) begin
            ram_addr  <= if_addr;
            ram_we    <= 1'b0;
            owner     <= 1'b0;
        end
    end

    // RAM strobe: registered from the grant so it is high only in ISSUE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_en <= 1'b0;
        end else begin
            ram_en <= grant_any;
        end
    end

    // Anti-starvation counter: moves only on contested grants, except that
    // any IF grant clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (grant_if) begin
            starve_cnt <= 4'd0;
        end else if (grant_mem && contested && (starve_cnt < STARVE_W)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Latency counter: loaded in ISSUE, counts down through WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (state == ISSUE) begin
            wait_cnt <= LAT_W;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Read data capture on the last WAIT cycle, exactly MEM_LAT cycles after
    // ram_en; writes leave both data registers alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_rdata  <= 32'd0;
            mem_rdata <= 32'd0;
        end else if (last_wait && !ram_we) begin
            if (owner) begin
                mem_rdata <= ram_rdata;
            end else begin
                if_rdata <= ram_rdata;
            end
        end
    end

    // Ready pulses: registered from the last WAIT cycle so they appear in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            if_ready  <= last_wait & ~owner;
            mem_ready <= last_wait & owner;
        end
    end

    // Structural invariants of the sequencing.
    a_ready_exclusive: assert property (@(posedge clock) disable iff (reset)
        !(if_ready && mem_ready));
    a_en_in_issue: assert property (@(posedge clock) disable iff (reset)
        ram_en |-> (state == ISSUE));

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter. Three copies run from the same
// requester stimulus with MEM_LAT = 2, 1 and 5; lane 0 (MEM_LAT=2) carries
// most checks, lanes 1 and 2 cover the latency boundaries. Each lane has a
// RAM model that presents the addressed word only in the single cycle
// MEM_LAT after ram_en and a cycle-stamped junk word in every other cycle.
module tb_pipe_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- shared stimulus ----------------
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // ---------------- per-lane outputs ----------------
  logic [31:0] if_rdata_w  [3];
  logic        if_ready_w  [3];
  logic [31:0] mem_rdata_w [3];
  logic        mem_ready_w [3];
  logic        stall_if_w  [3];
  logic        stall_mem_w [3];
  logic        ram_en_w    [3];
  logic        ram_we_w    [3];
  logic [31:0] ram_addr_w  [3];
  logic [31:0] ram_wdata_w [3];
  logic        owner_w     [3];
  logic [1:0]  state_dbg_w [3];

  logic [15:0] cyc;

  always @(posedge clock) cyc <= cyc + 16'd1;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h8C01_0004;
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    logic [31:0] rd;
    logic [3:0]  cnt;
    logic [31:0] a_lat;

    pipe_mem_arbiter #(.MEM_LAT(LAT), .MAX_STARVE(4)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata_w[g]),
      .if_ready  (if_ready_w[g]),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata_w[g]),
      .mem_ready (mem_ready_w[g]),
      .stall_if  (stall_if_w[g]),
      .stall_mem (stall_mem_w[g]),
      .ram_en    (ram_en_w[g]),
      .ram_we    (ram_we_w[g]),
      .ram_addr  (ram_addr_w[g]),
      .ram_wdata (ram_wdata_w[g]),
      .ram_rdata (rd),
      .owner     (owner_w[g]),
      .state_dbg (state_dbg_w[g])
    );

    // RAM model: real data only in cycle (ram_en cycle + LAT).
    always @(posedge clock) begin
      if (ram_en_w[g] && LAT == 1) rd <= data_of(ram_addr_w[g]);
      else if (cnt == 4'd1) rd <= data_of(a_lat);
      else rd <= 32'hBAD0_0000 | {16'h0000, cyc};
      if (reset) cnt <= 4'd0;
      else if (ram_en_w[g]) begin
        cnt   <= 4'(LAT - 1);
        a_lat <= ram_addr_w[g];
      end else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

  // lane 0 aliases
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_ready, mem_ready, stall_if, stall_mem, ram_en, ram_we, owner;
  logic [1:0]  state_dbg;
  assign if_rdata  = if_rdata_w[0];
  assign mem_rdata = mem_rdata_w[0];
  assign ram_addr  = ram_addr_w[0];
  assign ram_wdata = ram_wdata_w[0];
  assign if_ready  = if_ready_w[0];
  assign mem_ready = mem_ready_w[0];
  assign stall_if  = stall_if_w[0];
  assign stall_mem = stall_mem_w[0];
  assign ram_en    = ram_en_w[0];
  assign ram_we    = ram_we_w[0];
  assign owner     = owner_w[0];
  assign state_dbg = state_dbg_w[0];

  // ---------------- scoreboard ----------------
  int n_vec;
  int n_miss;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    if_req    = 1'b0;
    if_addr   = 32'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ram_en"},    ram_en,    0);
    check_eq({tag, "_ram_we"},    ram_we,    0);
    check_eq({tag, "_ram_addr"},  ram_addr,  0);
    check_eq({tag, "_ram_wdata"}, ram_wdata, 0);
    check_eq({tag, "_if_rdata"},  if_rdata,  0);
    check_eq({tag, "_mem_rdata"}, mem_rdata, 0);
    check_eq({tag, "_if_ready"},  if_ready,  0);
    check_eq({tag, "_mem_ready"}, mem_ready, 0);
    check_eq({tag, "_owner"},     owner,     0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_vec  = 0;
    n_miss = 0;
    cyc    = 16'd0;
    reset  = 1'b1;
    drive_idle();
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    check_eq("reset_state", state_dbg, 0);
    reset = 1'b0;

    // Test 1: IF-only read of 0x40.
    if_req  = 1'b1;
    if_addr = 32'h40;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) #1; else @(negedge clock);
      check_eq($sformatf("t1_ram_en@%0d", n),    ram_en,    32'(n == 1));
      check_eq($sformatf("t1_if_ready@%0d", n),  if_ready,  32'(n == 4));
      check_eq($sformatf("t1_stall_if@%0d", n),  stall_if,  32'(n < 4));
      check_eq($sformatf("t1_mem_ready@%0d", n), mem_ready, 0);
      if (n == 1) begin
        check_eq("t1_ram_addr", ram_addr, 32'h40);
        check_eq("t1_ram_we",   ram_we,   0);
        check_eq("t1_owner",    owner,    0);
      end
      if (n == 4) if_req = 1'b0;
    end
    check_eq("t1_if_rdata", if_rdata, 32'h8C01_0004);

    // Test 2: MEM write.
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h100;
    mem_wdata = 32'hDEAD_BEEF;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) #1; else @(negedge clock);
      check_eq($sformatf("t2_ram_en@%0d", n),    ram_en,    32'(n == 1));
      check_eq($sformatf("t2_mem_ready@%0d", n), mem_ready, 32'(n == 4));
      check_eq($sformatf("t2_stall_mem@%0d", n), stall_mem, 32'(n < 4));
      if (n == 1 || n == 5) begin
        check_eq($sformatf("t2_ram_we@%0d", n),    ram_we,    1);
        check_eq($sformatf("t2_ram_addr@%0d", n),  ram_addr,  32'h100);
        check_eq($sformatf("t2_ram_wdata@%0d", n), ram_wdata, 32'hDEAD_BEEF);
      end
      if (n == 4) mem_req = 1'b0;
    end
    check_eq("t2_mem_rdata", mem_rdata, 0);
    check_eq("t2_if_rdata_hold", if_rdata, 32'h8C01_0004);

    // Test 3: simultaneous IF and MEM read requests.
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h200;
    if_req   = 1'b1;
    if_addr  = 32'h44;
    for (int n = 0; n < 11; n++) begin
      if (n == 0) #1; else @(negedge clock);
      check_eq($sformatf("t3_ram_en@%0d", n),    ram_en,    32'(n == 1 || n == 6));
      check_eq($sformatf("t3_mem_ready@%0d", n), mem_ready, 32'(n == 4));
      check_eq($sformatf("t3_if_ready@%0d", n),  if_ready,  32'(n == 9));
      check_eq($sformatf("t3_stall_if@%0d", n),  stall_if,  32'(n < 9));
      check_eq($sformatf("t3_stall_mem@%0d", n), stall_mem, 32'(n < 4));
      check_eq($sformatf("t3_owner@%0d", n),     owner,     32'(n < 6));
      if (n == 1) check_eq("t3_ram_addr_mem", ram_addr, 32'h200);
      if (n == 6) check_eq("t3_ram_addr_if",  ram_addr, 32'h44);
      if (n == 4) mem_req = 1'b0;
      if (n == 9) if_req = 1'b0;
    end
    check_eq("t3_mem_rdata", mem_rdata, data_of(32'h200));
    check_eq("t3_if_rdata",  if_rdata,  data_of(32'h44));

    // Test 4: starvation override with both requests held high.
    do_reset();
    if_req   = 1'b1;
    if_addr  = 32'h48;
    mem_req  = 1'b1;
    mem_addr = 32'h300;
    exp_q = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd1};
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
      @(negedge clock);
      check_eq($sformatf("t4_ready_excl@%0d", n), if_ready & mem_ready, 0);
      if (ram_en) begin
        logic [31:0] exp_owner;
        exp_owner = exp_q.pop_front();
        check_eq($sformatf("t4_grant_owner@%0d", n), owner, exp_owner);
        check_eq($sformatf("t4_grant_addr@%0d", n), ram_addr,
                 (exp_owner == 32'd1) ? 32'h300 : 32'h48);
      end
    end
    check_eq("t4_grants_pending", exp_q.size(), 0);
    if_req = 1'b0;

    // Test 5: reset while the 6th access (MEM read) is in WAIT.
    @(negedge clock);
    check_eq("t5_in_wait", state_dbg, 2);
    reset   = 1'b1;
    mem_req = 1'b0;
    #1;
    check_all_zero("t5_async");
    for (int n = 0; n < 2; n++) begin
      @(negedge clock);
      check_eq($sformatf("t5_no_mem_ready@%0d", n), mem_ready, 0);
      check_eq($sformatf("t5_no_ram_en@%0d", n),    ram_en,    0);
    end
    reset   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h4C;
    for (int n = 0; n < 5; n++) begin
      if (n == 0) #1; else @(negedge clock);
      check_eq($sformatf("t5_ram_en@%0d", n),    ram_en,    32'(n == 1));
      check_eq($sformatf("t5_if_ready@%0d", n),  if_ready,  32'(n == 4));
      check_eq($sformatf("t5_mem_ready@%0d", n), mem_ready, 0);
      if (n == 1) check_eq("t5_ram_addr", ram_addr, 32'h4C);
      if (n == 4) if_req = 1'b0;
    end
    check_eq("t5_if_rdata", if_rdata, data_of(32'h4C));

    // Test 6: latency boundaries MEM_LAT=1 (lane 1) and MEM_LAT=5 (lane 2).
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h50;
    for (int n = 0; n < 9; n++) begin
      if (n == 0) #1; else @(negedge clock);
      if (n <= 4) begin
        check_eq($sformatf("t6_l1_ram_en@%0d", n),   ram_en_w[1],   32'(n == 1));
        check_eq($sformatf("t6_l1_if_ready@%0d", n), if_ready_w[1], 32'(n == 3));
      end
      if (n == 2) check_eq("t6_l1_rdata_early", if_rdata_w[1], 0);
      if (n == 3) check_eq("t6_l1_rdata", if_rdata_w[1], data_of(32'h50));
      check_eq($sformatf("t6_l5_ram_en@%0d", n),   ram_en_w[2],   32'(n == 1));
      check_eq($sformatf("t6_l5_if_ready@%0d", n), if_ready_w[2], 32'(n == 7));
      check_eq($sformatf("t6_l5_stall_if@%0d", n), stall_if_w[2], 32'(n < 7));
      if (n == 6) check_eq("t6_l5_rdata_early", if_rdata_w[2], 0);
      if (n == 7) begin
        check_eq("t6_l5_rdata", if_rdata_w[2], data_of(32'h50));
        if_req = 1'b0;
      end
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
